// File: rtl/pingpong_transpose_rd.sv
// pingpong_transpose_rd: two-bank tile buffer, row-major in; column-major out with PP_TRANSPOSE_EN, linear out otherwise
module pingpong_transpose_rd #(
    parameter int DAT_WIDTH  = 16,
    parameter int MEM_DEPTH  = 16,
    parameter int log2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [log2_DEPTH-1:0] num_rows,
    input  logic [log2_DEPTH-1:0] num_cols,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [DAT_WIDTH-1:0]  wr_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DAT_WIDTH-1:0]  out_dat,
    output logic                  out_last,
    output logic                  done
);
    typedef logic [log2_DEPTH-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    logic [DAT_WIDTH-1:0] r_mem [2][MEM_DEPTH];
    logic [1:0] r_full;
    cnt_t       r_R [2];
    cnt_t       r_C [2];
    logic       r_wsel, r_rsel, r_done;
    cnt_t       r_waddr, r_wc, r_wr, r_raddr, r_rr, r_rc;

    logic w_wacc, w_first, w_wcol_end, w_wlast, w_rhs, w_rrow_end;
    cnt_t w_wR, w_wC, w_rR, w_rC, w_raddr_nxt;

    // the first word of a tile compares against the live ports, since the latch lands this same edge
    assign w_first    = (r_wc == '0) && (r_wr == '0);
    assign w_wR       = w_first ? num_rows : r_R[r_wsel];
    assign w_wC       = w_first ? num_cols : r_C[r_wsel];
    assign wr_rdy     = !r_full[r_wsel];
    assign w_wacc     = wr_vld && wr_rdy;
    assign w_wcol_end = r_wc == w_wC;
    assign w_wlast    = w_wcol_end && (r_wr == w_wR);

    assign w_rR       = r_R[r_rsel];
    assign w_rC       = r_C[r_rsel];
    assign out_vld    = r_full[r_rsel];
    assign out_dat    = out_vld ? r_mem[r_rsel][r_raddr] : '0;
    assign w_rrow_end = r_rr == w_rR;
    assign out_last   = out_vld && w_rrow_end && (r_rc == w_rC);
    assign w_rhs      = out_vld && out_rdy;
    assign done       = r_done;

`ifdef PP_TRANSPOSE_EN
    assign w_raddr_nxt = w_rrow_end ? r_rc + ONE : r_raddr + w_rC + ONE;
`else
    assign w_raddr_nxt = r_raddr + ONE;
`endif

    always_ff @(posedge clk) begin
        if (w_wacc)
            r_mem[r_wsel][r_waddr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= '0;
            r_R     <= '{default: '0};
            r_C     <= '{default: '0};
            r_wsel  <= 1'b0;
            r_rsel  <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= '0;
            r_wc    <= '0;
            r_wr    <= '0;
            r_raddr <= '0;
            r_rr    <= '0;
            r_rc    <= '0;
        end else begin
            r_done <= w_rhs && out_last;
            if (w_wacc) begin
                if (w_first) begin
                    r_R[r_wsel] <= num_rows;
                    r_C[r_wsel] <= num_cols;
                end
                if (w_wlast) begin
                    r_full[r_wsel] <= 1'b1;
                    r_wsel         <= ~r_wsel;
                    r_waddr        <= '0;
                    r_wc           <= '0;
                    r_wr           <= '0;
                end else begin
                    r_waddr <= r_waddr + ONE;
                    r_wc    <= w_wcol_end ? '0 : r_wc + ONE;
                    r_wr    <= w_wcol_end ? r_wr + ONE : r_wr;
                end
            end
            // write and read banks differ whenever both end a tile together
            if (w_rhs) begin
                if (out_last) begin
                    r_full[r_rsel] <= 1'b0;
                    r_rsel         <= ~r_rsel;
                    r_raddr        <= '0;
                    r_rr           <= '0;
                    r_rc           <= '0;
                end else begin
                    r_raddr <= w_raddr_nxt;
                    r_rr    <= w_rrow_end ? '0 : r_rr + ONE;
                    r_rc    <= w_rrow_end ? r_rc + ONE : r_rc;
                end
            end
        end
    end
endmodule

// File: doc/pingpong_transpose_rd.md
# pingpong_transpose_rd

Ping-pong transpose buffer, the stage directly downstream of the ping-pong write-address generator in the TT core datapath. It accepts a row-major stream of an (R+1)×(C+1) tile into one of two register banks. Once a bank holds a complete tile, it streams the tile out column-major (transposed) to the next TT contraction stage, while the other bank fills. Both sides use valid/ready handshakes, and a registered `done` pulse follows the end of each tile readout.

## Interface
- `DAT_WIDTH`, 16, data word width
- `MEM_DEPTH`, 16, words per bank
- `log2_DEPTH`, 4, address / count width; `MEM_DEPTH` = 2^`log2_DEPTH`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `num_rows`  in  `log2_DEPTH`  tile rows minus one (R); sampled at the first accepted word of each bank
- `num_cols`  in  `log2_DEPTH`  tile columns minus one (C); sampled with `num_rows`
- `wr_vld`  in  1  input word valid
- `wr_rdy`  out  1  input ready = current write bank not full
- `wr_dat`  in  `DAT_WIDTH`  input word, row-major order
- `out_vld`  out  1  output word valid = current read bank full
- `out_rdy`  in  1  downstream ready
- `out_dat`  out  `DAT_WIDTH`  output word; 0 while `out_vld`=0
- `out_last`  out  1  high with the final word of a tile
- `done`  out  1  registered one-cycle pulse, cycle after the last-word handshake

## Operation
- State per bank b∈{0,1}:
  - `full[b]`
  - latched `R[b]` and `C[b]`
  - `MEM_DEPTH`×`DAT_WIDTH` register array
- Pointers:
  - `wsel`: bank being written
  - `rsel`: bank being read
  - both reset to 0
- Write side, accept = `wr_vld` & `wr_rdy`:
  - Word stored at linear address `waddr`.
  - Column counter `wc` and row counter `wr` track tile position.
  - Latching: on the first accept of a tile (`wc`=`wr`=0), `R[wsel]`/`C[wsel]` latch from the ports in the same cycle. For that word, the comparison uses the port values.
  - Stepping: `wc`==C → `wc`=0, `wr`++. Otherwise `wc`++. `waddr`++ on every accept.
  - Tile end: accept with `wc`==C and `wr`==R sets `full[wsel]`, toggles `wsel`, and clears `waddr`/`wc`/`wr`.
- Read side, handshake = `out_vld` & `out_rdy`:
  - Address `raddr`, row counter `rr`, column counter `rc`, all starting at 0.
  - `out_dat` = mem[`rsel`][`raddr`], combinational from registers.
  - Transposed step:
    - `rr`==R → `rr`=0, `rc`++, `raddr`=`rc`+1.
    - Otherwise `rr`++, `raddr`+=C+1.
  - `out_last` = `out_vld` & (`rr`==R) & (`rc`==C).
  - A handshake with `out_last` clears `full[rsel]`, toggles `rsel`, and clears `rr`/`rc`/`raddr`.
- Arithmetic:
  - All counters are `log2_DEPTH` bits.
  - Configuration must satisfy (R+1)(C+1) ≤ `MEM_DEPTH`. Behaviour outside this is undefined and not checked.
  - `raddr` never exceeds (R+1)(C+1)−1.
- Concurrency:
  - Write and read always address different banks whenever both are active, since writes require `!full[wsel]` and reads require `full[rsel]`.
  - A write-side tile end and a read-side tile end in the same cycle are handled independently.
- Degenerate tile R=C=0: one word per tile; `out_last` is high on that word.

## Timing
- Reset, applied in the cycle `rst` is sampled high:
  - `full`=0, `wsel`=`rsel`=0, all counters 0.
  - Outputs: `wr_rdy`=1, `out_vld`=0, `out_dat`=0, `out_last`=0, `done`=0.
  - Memory contents are not cleared.
- Reset mid-tile discards both banks' partial and full tiles.
- `wr_rdy`, `out_vld` and `out_last` are combinational from registers only. There is no combinational path from `wr_vld` or `out_rdy`.
- Latency: last write accept at edge N → `out_vld`=1 from cycle N+1.
- Throughput:
  - With `out_rdy` held high, one output word per cycle.
  - With both banks free, one input word per cycle.
  - When both banks are full, `wr_rdy`=0.
- `done` asserts in the cycle after the `out_last` handshake, for exactly one cycle.
- `out_dat` must hold stable while `out_vld`=1 and `out_rdy`=0.

## Configuration
- Macro: `PP_TRANSPOSE_EN`.
- Defined: column-major (transposed) readout as described above.
- Not defined:
  - Readout is linear: `raddr`++ each handshake, 0…(R+1)(C+1)−1.
  - `rr`/`rc` still count, so `out_last` and `done` timing are identical.

## Test plan
- R=1, C=2, write 0,1,2,3,4,5 back-to-back, `out_rdy`=1 → `out_dat` 0,3,1,4,2,5; `out_last` with 5; `done` one cycle later. Without the macro → 0,1,2,3,4,5.
- Two tiles 2×2 (10,11,12,13 then 20,21,22,23) with `out_rdy`=0 → `wr_rdy` drops after 8 accepts. Then `out_rdy`=1 → 10,12,11,13,20,22,21,23; two `done` pulses.
- R=C=0, single word 0xABCD → `out_vld` next cycle, `out_last`=1, `done` pulse; `wr_rdy` stays 1.
- Random `out_rdy` toggling on a 4×4 tile (R=C=3) → `out_dat` stable while stalled; order 0,4,8,12,1,5,…,15.
- `rst`=1 for one cycle after 3 words of a 2×3 tile and one full bank → `out_vld`=0, `wr_rdy`=1. A fresh 2×3 tile reads out correctly.
- `num_rows`/`num_cols` changed mid-tile from 1/2 to 3/3 → current tile still uses 1/2; the next tile uses 3/3.
